// File: rtl/isqrt_arbiter_if.sv
// Bundle between the requesters plus the shared isqrt instance (master side)
// and the isqrt_arbiter (slave side).
interface isqrt_arbiter_if #(
    parameter int N_REQ   = 3,
    parameter int MAX_OUT = 8
);
    logic [N_REQ-1:0]         req_vld;
    logic [32*N_REQ-1:0]      req_x;
    logic [N_REQ-1:0]         req_rdy;
    logic [N_REQ-1:0]         rsp_vld;
    logic [15:0]              rsp_y;
    logic                     isqrt_x_vld;
    logic [31:0]              isqrt_x;
    logic                     isqrt_y_vld;
    logic [15:0]              isqrt_y;
    logic [$clog2(MAX_OUT):0] outstanding;
    logic                     err_orphan;

    modport slave (
        input  req_vld, req_x, isqrt_y_vld, isqrt_y,
        output req_rdy, rsp_vld, rsp_y, isqrt_x_vld, isqrt_x, outstanding, err_orphan
    );

    modport master (
        output req_vld, req_x, isqrt_y_vld, isqrt_y,
        input  req_rdy, rsp_vld, rsp_y, isqrt_x_vld, isqrt_x, outstanding, err_orphan
    );
endinterface

// File: rtl/isqrt_arbiter.sv
// Round-robin sharing of one pipelined isqrt between N_REQ requesters; an in-order
// tag FIFO remembers who issued each request so results are routed back.
module isqrt_arbiter #(
    parameter int N_REQ   = 3,
    parameter int MAX_OUT = 8
) (
    input logic            clk,
    input logic            rst,
    isqrt_arbiter_if.slave bus
);
    localparam int TW = $clog2(N_REQ);
    localparam int PW = $clog2(MAX_OUT);
    localparam int CW = PW + 1;
    localparam logic [TW:0]   N_REQ_W   = (TW+1)'(N_REQ);
    localparam logic [TW-1:0] LAST_REQ  = TW'(N_REQ - 1);
    localparam logic [CW-1:0] MAX_OUT_W = CW'(MAX_OUT);

    function automatic logic [N_REQ-1:0] tag_onehot(input logic [TW-1:0] tag);
        return N_REQ'(1'b1) << tag;
    endfunction

    function automatic logic [TW-1:0] next_req(input logic [TW-1:0] idx);
        if (idx == LAST_REQ) begin
            return {TW{1'b0}};
        end else begin
            return idx + TW'(1'b1);
        end
    endfunction

    logic [TW-1:0]    rr_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [TW-1:0]    tag_mem_r [MAX_OUT];
    logic             err_orphan_r;

    logic             fifo_empty_s;
    logic             pop_s;
    logic             orphan_s;
    logic             can_issue_s;
    logic             found_s;
    logic             push_s;
    logic [TW:0]      scan_sum_s;
    logic [TW-1:0]    scan_idx_s;
    logic [TW-1:0]    winner_s;
    logic [N_REQ-1:0] req_rdy_s;
    logic [31:0]      issue_x_s;
    logic [N_REQ-1:0] rsp_vld_s;
    logic [15:0]      rsp_y_s;

    // Return path: pop the head tag and steer the result to its owner.
    // Gated by rst so nothing is delivered while the isqrt pipeline is being cleared.
    always_comb begin
        fifo_empty_s = (count_r == {CW{1'b0}});
        pop_s        = bus.isqrt_y_vld & ~fifo_empty_s & ~rst;
        orphan_s     = bus.isqrt_y_vld & fifo_empty_s;
        if (pop_s) begin
            rsp_vld_s = tag_onehot(tag_mem_r[rd_ptr_r]);
            rsp_y_s   = bus.isqrt_y;
        end else begin
            rsp_vld_s = {N_REQ{1'b0}};
            rsp_y_s   = 16'd0;
        end
    end

    // Round-robin scan starting at rr_ptr_r. Walking the offsets downward lets the
    // lowest offset (closest to rr_ptr_r) overwrite the others.
    // Timing note: isqrt_y_vld reaches isqrt_x_vld through can_issue_s by design
    // (a full FIFO may accept a push in the cycle it pops); constrain that path.
    always_comb begin
        can_issue_s = (count_r < MAX_OUT_W) | bus.isqrt_y_vld;
        found_s     = |bus.req_vld;
        winner_s    = {TW{1'b0}};
        scan_sum_s  = {(TW+1){1'b0}};
        scan_idx_s  = {TW{1'b0}};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_sum_s = {1'b0, rr_ptr_r} + (TW+1)'(k);
            if (scan_sum_s >= N_REQ_W) begin
                scan_idx_s = TW'(scan_sum_s - N_REQ_W);
            end else begin
                scan_idx_s = scan_sum_s[TW-1:0];
            end
            if (bus.req_vld[scan_idx_s]) begin
                winner_s = scan_idx_s;
            end else begin
                winner_s = winner_s;
            end
        end
        push_s = found_s & can_issue_s;
        if (push_s) begin
            req_rdy_s = tag_onehot(winner_s);
            issue_x_s = bus.req_x[{winner_s, 5'b00000} +: 32];
        end else begin
            req_rdy_s = {N_REQ{1'b0}};
            issue_x_s = 32'd0;
        end
    end

    // Arbiter pointer, FIFO pointers, outstanding count and sticky orphan flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r     <= {TW{1'b0}};
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            count_r      <= {CW{1'b0}};
            err_orphan_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
                rr_ptr_r <= next_req(winner_s);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
            if (orphan_s) begin
                err_orphan_r <= 1'b1;
            end
        end
    end

    // Tag storage; contents are only read while the count says they are valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            tag_mem_r[wr_ptr_r] <= winner_s;
        end
    end

    assign bus.req_rdy     = req_rdy_s;
    assign bus.isqrt_x_vld = push_s;
    assign bus.isqrt_x     = issue_x_s;
    assign bus.rsp_vld     = rsp_vld_s;
    assign bus.rsp_y       = rsp_y_s;
    assign bus.outstanding = count_r;
    assign bus.err_orphan  = err_orphan_r;

endmodule

// File: tb/tb_isqrt_arbiter.sv
// Directed bench for isqrt_arbiter: dut_a (MAX_OUT=8, isqrt latency 3) and
// dut_b (MAX_OUT=2, isqrt latency 4) each behind a small isqrt pipeline model.
module tb_isqrt_arbiter;
    localparam int LAT_A = 3;
    localparam int LAT_B = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    isqrt_arbiter_if #(.N_REQ(3), .MAX_OUT(8)) bus_a ();
    isqrt_arbiter_if #(.N_REQ(3), .MAX_OUT(2)) bus_b ();

    isqrt_arbiter #(.N_REQ(3), .MAX_OUT(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    isqrt_arbiter #(.N_REQ(3), .MAX_OUT(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    function automatic logic [15:0] ref_isqrt(input logic [31:0] x);
        for (longint r = 0; r < 65536; r++) begin
            if ((r + 1) * (r + 1) > longint'(x)) return 16'(r);
        end
        return 16'hFFFF;
    endfunction

    // isqrt pipeline models
    logic [LAT_A-1:0] pa_vld;
    logic [31:0]      pa_x [LAT_A];
    logic [LAT_B-1:0] pb_vld;
    logic [31:0]      pb_x [LAT_B];
    logic             orphan_a;

    always @(posedge clk) begin
        if (rst) begin
            pa_vld <= '0;
            pb_vld <= '0;
            for (int k = 0; k < LAT_A; k++) pa_x[k] <= 32'd0;
            for (int k = 0; k < LAT_B; k++) pb_x[k] <= 32'd0;
        end else begin
            pa_vld  <= {pa_vld[LAT_A-2:0], bus_a.isqrt_x_vld};
            pb_vld  <= {pb_vld[LAT_B-2:0], bus_b.isqrt_x_vld};
            pa_x[0] <= bus_a.isqrt_x;
            pb_x[0] <= bus_b.isqrt_x;
            for (int k = 1; k < LAT_A; k++) pa_x[k] <= pa_x[k-1];
            for (int k = 1; k < LAT_B; k++) pb_x[k] <= pb_x[k-1];
        end
    end

    assign bus_a.isqrt_y_vld = pa_vld[LAT_A-1] | orphan_a;
    assign bus_a.isqrt_y     = ref_isqrt(pa_x[LAT_A-1]);
    assign bus_b.isqrt_y_vld = pb_vld[LAT_B-1];
    assign bus_b.isqrt_y     = ref_isqrt(pb_x[LAT_B-1]);

    // Record grants and responses of dut_a
    logic [18:0] rsp_q [$];
    logic [2:0]  gnt_q [$];
    always @(negedge clk) begin
        if (bus_a.rsp_vld != 3'b000) rsp_q.push_back({bus_a.rsp_vld, bus_a.rsp_y});
        if (bus_a.isqrt_x_vld) gnt_q.push_back(bus_a.req_rdy);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic reset_pulse(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic clear_q();
        rsp_q.delete();
        gnt_q.delete();
    endtask

    logic [18:0] exp_rsp_c [6];
    logic [2:0]  exp_gnt_c [6];
    logic [18:0] exp_rsp_f [5];
    logic [2:0]  exp_gnt_f [5];
    logic        exp_rdy_b [6];
    logic [2:0]  exp_out_b [6];

    initial begin
        exp_gnt_c = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        exp_rsp_c = '{{3'b001, 16'd10}, {3'b010, 16'd20}, {3'b100, 16'd30},
                      {3'b001, 16'd10}, {3'b010, 16'd20}, {3'b100, 16'd30}};
        exp_gnt_f = '{3'b010, 3'b100, 3'b010, 3'b100, 3'b010};
        exp_rsp_f = '{{3'b010, 16'd7}, {3'b100, 16'd8}, {3'b010, 16'd7},
                      {3'b100, 16'd8}, {3'b010, 16'd7}};
        exp_rdy_b = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_out_b = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2};

        bus_a.req_vld = 3'b000;
        bus_a.req_x   = '0;
        bus_b.req_vld = 3'b000;
        bus_b.req_x   = '0;
        orphan_a      = 1'b0;

        // Reset state
        reset_pulse(3);
        settle();
        check_val("rst_outstanding", 32'(bus_a.outstanding), 32'd0);
        check_val("rst_err_orphan", 32'(bus_a.err_orphan), 32'd0);
        check_val("rst_rsp_vld", 32'(bus_a.rsp_vld), 32'd0);
        check_val("rst_req_rdy", 32'(bus_a.req_rdy), 32'd0);
        check_val("rst_x_vld", 32'(bus_a.isqrt_x_vld), 32'd0);

        // Single requester: sqrt(16) = 4
        clear_q();
        step();
        bus_a.req_x   = {32'd0, 32'd0, 32'd16};
        bus_a.req_vld = 3'b001;
        settle();
        check_val("single_x_vld", 32'(bus_a.isqrt_x_vld), 32'd1);
        check_val("single_x", bus_a.isqrt_x, 32'd16);
        check_val("single_rdy", 32'(bus_a.req_rdy), 32'b001);
        step();
        bus_a.req_vld = 3'b000;
        settle();
        check_val("single_out1", 32'(bus_a.outstanding), 32'd1);
        repeat (6) step();
        settle();
        check_val("single_out0", 32'(bus_a.outstanding), 32'd0);
        check_val("single_nrsp", 32'(rsp_q.size()), 32'd1);
        check_val("single_rsp", (rsp_q.size() > 0) ? 32'(rsp_q[0]) : 32'hFFFFFFFF,
                  32'({3'b001, 16'd4}));

        // Contention: all three requesters for 6 cycles, x_i = 100*(i+1)^2
        reset_pulse(1);
        clear_q();
        bus_a.req_x   = {32'd900, 32'd400, 32'd100};
        bus_a.req_vld = 3'b111;
        repeat (6) step();
        bus_a.req_vld = 3'b000;
        repeat (8) step();
        settle();
        check_val("cont_ngnt", 32'(gnt_q.size()), 32'd6);
        check_val("cont_nrsp", 32'(rsp_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("cont_gnt%0d", i),
                      (i < gnt_q.size()) ? 32'(gnt_q[i]) : 32'hFFFFFFFF, 32'(exp_gnt_c[i]));
            check_val($sformatf("cont_rsp%0d", i),
                      (i < rsp_q.size()) ? 32'(rsp_q[i]) : 32'hFFFFFFFF, 32'(exp_rsp_c[i]));
        end
        check_val("cont_out0", 32'(bus_a.outstanding), 32'd0);

        // Fairness: one grant to requester 1 leaves rr_ptr=2, then 1 and 2 held
        clear_q();
        step();
        bus_a.req_x   = {32'd64, 32'd49, 32'd0};
        bus_a.req_vld = 3'b010;
        step();
        bus_a.req_vld = 3'b110;
        repeat (4) step();
        bus_a.req_vld = 3'b000;
        repeat (8) step();
        settle();
        check_val("fair_ngnt", 32'(gnt_q.size()), 32'd5);
        check_val("fair_nrsp", 32'(rsp_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("fair_gnt%0d", i),
                      (i < gnt_q.size()) ? 32'(gnt_q[i]) : 32'hFFFFFFFF, 32'(exp_gnt_f[i]));
            check_val($sformatf("fair_rsp%0d", i),
                      (i < rsp_q.size()) ? 32'(rsp_q[i]) : 32'hFFFFFFFF, 32'(exp_rsp_f[i]));
        end

        // Orphan result with an empty FIFO
        clear_q();
        step();
        orphan_a = 1'b1;
        settle();
        check_val("orph_rsp_vld", 32'(bus_a.rsp_vld), 32'd0);
        check_val("orph_err_pre", 32'(bus_a.err_orphan), 32'd0);
        step();
        orphan_a = 1'b0;
        settle();
        check_val("orph_err_set", 32'(bus_a.err_orphan), 32'd1);
        check_val("orph_out", 32'(bus_a.outstanding), 32'd0);
        repeat (3) step();
        settle();
        check_val("orph_err_sticky", 32'(bus_a.err_orphan), 32'd1);
        check_val("orph_nrsp", 32'(rsp_q.size()), 32'd0);

        // Reset with three requests in flight
        clear_q();
        step();
        bus_a.req_x   = {32'd0, 32'd0, 32'd16};
        bus_a.req_vld = 3'b001;
        repeat (3) step();
        bus_a.req_vld = 3'b000;
        rst = 1'b1;
        settle();
        check_val("mid_out3", 32'(bus_a.outstanding), 32'd3);
        check_val("mid_rsp_in_rst", 32'(bus_a.rsp_vld), 32'd0);
        step();
        rst = 1'b0;
        settle();
        check_val("mid_out0", 32'(bus_a.outstanding), 32'd0);
        check_val("mid_err_clr", 32'(bus_a.err_orphan), 32'd0);
        check_val("mid_rsp_vld", 32'(bus_a.rsp_vld), 32'd0);
        step();
        bus_a.req_x   = {32'd0, 32'd81, 32'd16};
        bus_a.req_vld = 3'b011;
        settle();
        check_val("mid_rdy", 32'(bus_a.req_rdy), 32'b001);
        check_val("mid_x", bus_a.isqrt_x, 32'd16);
        step();
        bus_a.req_vld = 3'b000;
        repeat (6) step();
        settle();
        check_val("mid_nrsp", 32'(rsp_q.size()), 32'd1);
        check_val("mid_rsp", (rsp_q.size() > 0) ? 32'(rsp_q[0]) : 32'hFFFFFFFF,
                  32'({3'b001, 16'd4}));

        // Full FIFO on dut_b: MAX_OUT=2, latency 4, requester 0 held
        step();
        bus_b.req_x   = {32'd0, 32'd0, 32'd25};
        bus_b.req_vld = 3'b001;
        for (int c = 0; c < 6; c++) begin
            settle();
            check_val($sformatf("full_rdy_c%0d", c), 32'(bus_b.req_rdy[0]), 32'(exp_rdy_b[c]));
            check_val($sformatf("full_out_c%0d", c), 32'(bus_b.outstanding), 32'(exp_out_b[c]));
            check_val($sformatf("full_rsp_c%0d", c), 32'(bus_b.rsp_vld),
                      (c >= 4) ? 32'b001 : 32'd0);
            check_val($sformatf("full_y_c%0d", c), 32'(bus_b.rsp_y),
                      (c >= 4) ? 32'd5 : 32'd0);
            step();
        end
        bus_b.req_vld = 3'b000;
        repeat (10) step();
        settle();
        check_val("full_drain", 32'(bus_b.outstanding), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
